// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter.
//   uart_state_e     : transmitter FSM states
//   PARITY_*         : parity mode selectors for PARITY_MODE
//   UART_DIV_115200  : clk cycles per bit for 12 MHz / 115200 baud
//   parity_bit()     : turns the XOR of the data bits into the transmitted parity bit
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  localparam int unsigned UART_DIV_115200 = 104;

  // Even parity sends the XOR of the data bits; odd parity sends its complement.
  function automatic logic parity_bit(input logic data_xor, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART transmitter.
//   clk      : system clock
//   reset_n  : asynchronous reset, active low
//   restart  : clears the count (held while idle and pulsed on each handshake)
//   tick     : high in the last clk cycle of every CLK_DIV-cycle bit period
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = UART_DIV_115200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
    $error("uart_baud_tick: CLK_DIV=%0d outside 2..65535", CLK_DIV);
  end

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: takes a word on a valid/ready handshake and sends it
// LSB-first as start bit, DATA_BITS data bits, optional parity bit and STOP_BITS stop bits.
//   clk       : system clock
//   reset_n   : asynchronous reset, active low
//   tx_valid  : producer has a word on tx_data
//   tx_data   : word to send, captured on the handshake edge only
//   tx_ready  : a word can be accepted this cycle (idle, or last cycle of the final stop bit)
//   tx_busy   : frame in progress
//   RS232_Tx  : registered serial line, idle high
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV     = UART_DIV_115200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = PARITY_NONE,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 RS232_Tx
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS=%0d outside 5..9", DATA_BITS);
  end
  if (PARITY_MODE > PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_param: PARITY_MODE=%0d not 0, 1 or 2", PARITY_MODE);
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS=%0d not 1 or 2", STOP_BITS);
  end

  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);
  localparam logic LastStop = 1'(STOP_BITS - 1);
  localparam bit HasParity = (PARITY_MODE != PARITY_NONE);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 tick, handshake, last_stop;

  uart_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_baud_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .restart(handshake || (state_q == StIdle)),
    .tick   (tick)
  );

  assign last_stop = (state_q == StStop) && tick && (stop_idx_q == LastStop);
  assign handshake = tx_valid && tx_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    parity_d   = parity_q;
    unique case (state_q)
      StIdle: ;
      StStart: begin
        if (tick) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LastIdx) begin
            state_d    = HasParity ? StParity : StStop;
            stop_idx_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          state_d    = StStop;
          stop_idx_d = 1'b0;
        end
      end
      StStop: begin
        if (tick) begin
          if (stop_idx_q == LastStop) begin
            state_d = StIdle;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // A handshake (idle or final stop cycle) loads the next frame, overriding the above.
    if (handshake) begin
      state_d  = StStart;
      shift_d  = tx_data;
      parity_d = parity_bit(^tx_data, PARITY_MODE);
    end
  end

  // The line register follows the next state so the start bit appears right after the
  // handshake edge and back-to-back frames abut without a gap.
  always_comb begin
    tx_ready = (state_q == StIdle) || last_stop;
    tx_busy  = (state_q != StIdle);
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  assign RS232_Tx = tx_q;

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;

  typedef bit bitq_t[$];

  logic            clk = 1'b0;
  logic            reset_n;
  logic [3:0]      valid;
  logic [3:0][8:0] data;
  logic [3:0]      tx_w, ready_w, busy_w;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // 0: 8N1, 1: 8E2, 2: 8O2 (all CLK_DIV=4); 3: 7N1 at CLK_DIV=104
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_n1 (
    .clk(clk), .reset_n(reset_n), .tx_valid(valid[0]), .tx_data(data[0][7:0]),
    .tx_ready(ready_w[0]), .tx_busy(busy_w[0]), .RS232_Tx(tx_w[0]));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)) u_e2 (
    .clk(clk), .reset_n(reset_n), .tx_valid(valid[1]), .tx_data(data[1][7:0]),
    .tx_ready(ready_w[1]), .tx_busy(busy_w[1]), .RS232_Tx(tx_w[1]));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2)) u_o2 (
    .clk(clk), .reset_n(reset_n), .tx_valid(valid[2]), .tx_data(data[2][7:0]),
    .tx_ready(ready_w[2]), .tx_busy(busy_w[2]), .RS232_Tx(tx_w[2]));
  uart_tx_param #(.CLK_DIV(104), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(1)) u_slow (
    .clk(clk), .reset_n(reset_n), .tx_valid(valid[3]), .tx_data(data[3][6:0]),
    .tx_ready(ready_w[3]), .tx_busy(busy_w[3]), .RS232_Tx(tx_w[3]));

  function automatic int div_of(int i);   return (i == 3) ? 104 : 4; endfunction
  function automatic int dbits_of(int i); return (i == 3) ? 7 : 8; endfunction
  function automatic int par_of(int i);   return (i == 1) ? 1 : ((i == 2) ? 2 : 0); endfunction
  function automatic int stop_of(int i);  return (i == 1 || i == 2) ? 2 : 1; endfunction
  function automatic logic [8:0] mask_of(int i);
    return (i == 3) ? 9'h07F : 9'h0FF;
  endfunction

  // Reference frame: the sequence of line levels, one entry per bit period.
  function automatic bitq_t frame_bits(int i, logic [8:0] w);
    bitq_t q;
    bit p = 1'b0;
    q.push_back(1'b0);
    for (int k = 0; k < dbits_of(i); k++) begin
      q.push_back(w[k]);
      p ^= w[k];
    end
    if (par_of(i) == 1) q.push_back(p);
    if (par_of(i) == 2) q.push_back(~p);
    for (int k = 0; k < stop_of(i); k++) q.push_back(1'b1);
    return q;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input int i);
    @(negedge clk);
    check("idle_tx", 32'(tx_w[i]), 32'd1);
    check("idle_busy", 32'(busy_w[i]), 32'd0);
    check("idle_ready", 32'(ready_w[i]), 32'd1);
  endtask

  // Present a word while idle; returns just after the handshake edge.
  task automatic start_frame(input int i, input logic [8:0] w);
    @(negedge clk);
    data[i]  = w;
    valid[i] = 1'b1;
    check("ready_before_hs", 32'(ready_w[i]), 32'd1);
    @(posedge clk);
  endtask

  // Check every cycle of one frame that was handshaken at the last posedge.
  // mode 0: drop valid and scribble on data; 1: keep valid, present nxt;
  // 2: keep valid, data changes every cycle. next_w is the word presented at the last cycle.
  task automatic run_frame(input int i, input logic [8:0] w, input int mode,
                           input logic [8:0] nxt, output logic [8:0] next_w);
    bitq_t      b;
    int         div, total;
    logic [8:0] dec;
    logic [8:0] wm;
    wm    = w & mask_of(i);
    b     = frame_bits(i, wm);
    div   = div_of(i);
    total = b.size() * div;
    dec   = '0;
    next_w = '0;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      check("line", 32'(tx_w[i]), 32'(b[c / div]));
      check("busy", 32'(busy_w[i]), 32'd1);
      check("ready", 32'(ready_w[i]), (c == total - 1) ? 32'd1 : 32'd0);
      // Monitor samples the middle of each data bit.
      if ((c % div) == div / 2 && c / div >= 1 && c / div <= dbits_of(i)) begin
        dec[c / div - 1] = tx_w[i];
      end
      if (mode == 0 && c == 0) begin
        valid[i] = 1'b0;
        data[i]  = 9'($urandom);
      end else if (mode == 1 && c == 0) begin
        data[i] = nxt;
      end else if (mode == 2) begin
        data[i] = 9'($urandom);
      end
      if (c == total - 1) next_w = data[i] & mask_of(i);
    end
    check("decoded", 32'(dec), 32'(wm));
  endtask

  initial begin
    logic [8:0] w, nw, nw2;
    reset_n = 1'b0;
    valid   = '0;
    data    = '0;

    // Reset held, then released with tx_valid low.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("rst_tx", 32'(tx_w[i]), 32'd1);
      check("rst_ready", 32'(ready_w[i]), 32'd1);
      check("rst_busy", 32'(busy_w[i]), 32'd0);
    end
    reset_n = 1'b1;
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 4; i++) idle_check_now(i);
      @(negedge clk);
    end

    // Single 8N1 frame of 0x55.
    start_frame(0, 9'h055);
    run_frame(0, 9'h055, 0, 9'h0, nw);
    idle_check(0);

    // Back-to-back 0xA3 then 0x0F with continuous valid.
    start_frame(0, 9'h0A3);
    run_frame(0, 9'h0A3, 1, 9'h00F, nw);
    run_frame(0, nw, 0, 9'h0, nw2);
    idle_check(0);

    // Even and odd parity with 0x07 and two stop bits, then random words.
    for (int i = 1; i <= 2; i++) begin
      start_frame(i, 9'h007);
      run_frame(i, 9'h007, 0, 9'h0, nw);
      idle_check(i);
      for (int r = 0; r < 3; r++) begin
        w = 9'($urandom);
        start_frame(i, w);
        run_frame(i, w, 0, 9'h0, nw);
        idle_check(i);
      end
    end

    // Random 8N1 words.
    for (int r = 0; r < 4; r++) begin
      w = 9'($urandom);
      start_frame(0, w);
      run_frame(0, w, 0, 9'h0, nw);
      idle_check(0);
    end

    // Reset in the middle of data bit 3 (bit 3 forced to 0 so the abort is visible).
    w = 9'($urandom) & 9'h0F7;
    start_frame(0, w);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    check("bit3_before_rst", 32'(tx_w[0]), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx_w[0]), 32'd1);
    check("rst_async_busy", 32'(busy_w[0]), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 12; n++) idle_check(0);
    w = 9'($urandom);
    start_frame(0, w);
    run_frame(0, w, 0, 9'h0, nw);
    idle_check(0);

    // Data changing under continuous valid: only handshake-edge words are sent.
    w = 9'($urandom);
    start_frame(0, w);
    run_frame(0, w, 2, 9'h0, nw);
    run_frame(0, nw, 2, 9'h0, nw2);
    run_frame(0, nw2, 0, 9'h0, nw);
    idle_check(0);

    // 7N1 at CLK_DIV=104: 9 bits of 104 cycles.
    start_frame(3, 9'h041);
    run_frame(3, 9'h041, 0, 9'h0, nw);
    idle_check(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Idle check at the current sample point (no clock wait).
  task automatic idle_check_now(input int i);
    check("post_rst_tx", 32'(tx_w[i]), 32'd1);
    check("post_rst_busy", 32'(busy_w[i]), 32'd0);
    check("post_rst_ready", 32'(ready_w[i]), 32'd1);
  endtask

endmodule
